// File: rtl/pmem_burst_model.sv
// pmem_burst_model
//   Synthesizable physical-memory model that sits below the cache/arbiter
//   hierarchy. Stores DEPTH lines of CACHE_LINE_WIDTH bits and serves NUM_CH
//   requesters through a round-robin arbiter. Each line moves as BURST_LEN
//   beats. The first beat arrives DELAY_PAGE_HIT cycles after the grant on an
//   open-page hit and DELAY_MEM cycles after it otherwise. Violations of the
//   request protocol raise a sticky error flag.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   ch_read   per-channel read request
//   ch_write  per-channel write request
//   ch_addr   per-channel byte address, channel i at [32*i +: 32]
//   ch_wdata  per-channel write beat
//   ch_rdata  per-channel read beat (holds its value when not updated)
//   ch_resp   per-channel beat-valid strobe
//   busy      a transaction is in progress
//   cur_ch    channel currently granted
//   error     sticky protocol-violation flag
module pmem_burst_model #(
  parameter int NUM_CH           = 2,
  parameter int DELAY_MEM        = 20,
  parameter int DELAY_PAGE_HIT   = 6,
  parameter int BURST_LEN        = 4,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int PAGE_SIZE        = 2048,
  parameter int DEPTH            = 1024
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_CH-1:0]                              ch_read,
  input  logic [NUM_CH-1:0]                              ch_write,
  input  logic [NUM_CH*32-1:0]                           ch_addr,
  input  logic [NUM_CH*(CACHE_LINE_WIDTH/BURST_LEN)-1:0] ch_wdata,
  output logic [NUM_CH*(CACHE_LINE_WIDTH/BURST_LEN)-1:0] ch_rdata,
  output logic [NUM_CH-1:0]                              ch_resp,
  output logic                                           busy,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cur_ch,
  output logic                                           error
);

  localparam int BW         = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAGE_BITS  = $clog2(PAGE_SIZE);
  localparam int PG_W       = 32 - PAGE_BITS;
  localparam int LINE_SHIFT = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_BITS  = $clog2(BURST_LEN);
  localparam int BEAT_W     = (BURST_LEN > 1) ? BEAT_BITS : 1;
  localparam int MA_W       = IDX_W + BEAT_BITS;
  localparam int MAX_DLY    = (DELAY_MEM > DELAY_PAGE_HIT) ? DELAY_MEM : DELAY_PAGE_HIT;
  localparam int CNT_W      = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_COOL} state_e;

  // Storage is organised as one word per beat so a beat write touches only
  // its own slice of the line.
  logic [BW-1:0] mem [DEPTH*BURST_LEN];

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic                      wr_q, wr_d;
  logic [31:0]               addr_q, addr_d;
  logic [CH_W-1:0]           rr_q, rr_d;
  logic [PG_W-1:0]           page_q, page_d;
  logic                      page_vld_q, page_vld_d;
  logic                      err_q, err_d;
  logic [NUM_CH-1:0][BW-1:0] rdata_q, rdata_d;

  logic [NUM_CH-1:0] elig;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [31:0]       gnt_addr;
  logic              hit;
  logic              cur_rd, cur_wr, viol;
  logic [31:0]       cur_addr;
  logic [IDX_W-1:0]  line;
  logic [BEAT_W-1:0] rd_beat;
  logic [BW-1:0]     rd_word;
  logic              mem_we;
  logic [BW-1:0]     mem_wdata;

  function automatic logic [MA_W-1:0] word_addr(input logic [IDX_W-1:0] l,
                                                input logic [BEAT_W-1:0] b);
    word_addr = (MA_W'(l) << BEAT_BITS) | MA_W'(b);
  endfunction

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      ch_q       <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      rr_q       <= '0;
      page_q     <= '0;
      page_vld_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      ch_q       <= ch_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      rr_q       <= rr_d;
      page_q     <= page_d;
      page_vld_q <= page_vld_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst, and an
  // unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr(line, beat_q)] <= mem_wdata;
  end

  // Next-state and datapath
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    ch_d       = ch_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    rr_d       = rr_q;
    page_d     = page_q;
    page_vld_d = page_vld_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;

    // Round-robin pick: scan from the highest offset down so that the last
    // eligible hit, which wins, is the first one at or after rr_q.
    elig   = ch_read ^ ch_write;
    gnt_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (elig[(int'(rr_q) + k) % NUM_CH]) gnt_ch = CH_W'((int'(rr_q) + k) % NUM_CH);
    end
    gnt_vld  = |elig;
    gnt_addr = ch_addr[32*int'(gnt_ch) +: 32];
    hit      = page_vld_q && (page_q == gnt_addr[31:PAGE_BITS]);

    // Protocol check on the granted channel while a transfer is open.
    cur_rd   = ch_read[ch_q];
    cur_wr   = ch_write[ch_q];
    cur_addr = ch_addr[32*int'(ch_q) +: 32];
    viol     = (wr_q ? (!cur_wr || cur_rd) : (!cur_rd || cur_wr)) || (cur_addr != addr_q);

    line      = addr_q[LINE_SHIFT +: IDX_W];
    mem_wdata = ch_wdata[BW*int'(ch_q) +: BW];
    // Read data is loaded on the edge that starts its beat: beat 0 when
    // leaving WAIT, beat i+1 at the end of beat i.
    rd_beat   = (state_q == S_BURST) ? beat_q + 1'b1 : '0;
    rd_word   = mem[word_addr(line, rd_beat)];

    unique case (state_q)
      S_IDLE: begin
        if (|(ch_read & ch_write)) err_d = 1'b1;
        if (gnt_vld) begin
          state_d    = S_WAIT;
          ch_d       = gnt_ch;
          wr_d       = ch_write[gnt_ch];
          addr_d     = gnt_addr;
          cnt_d      = hit ? CNT_W'(DELAY_PAGE_HIT - 1) : CNT_W'(DELAY_MEM - 1);
          page_d     = gnt_addr[31:PAGE_BITS];
          page_vld_d = 1'b1;
          rr_d       = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end
      end
      S_WAIT: begin
        if (viol) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_BURST;
          beat_d  = '0;
          if (!wr_q) rdata_d[ch_q] = rd_word;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BURST: begin
        if (viol) begin
          // Beats already written stay in storage; this one is dropped.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_we = wr_q;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = S_COOL;
          end else begin
            beat_d = beat_q + 1'b1;
            if (!wr_q) rdata_d[ch_q] = rd_word;
          end
        end
      end
      S_COOL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ch_resp = '0;
    if (state_q == S_BURST) ch_resp[ch_q] = 1'b1;
    busy     = (state_q != S_IDLE);
    cur_ch   = ch_q;
    error    = err_q;
    ch_rdata = rdata_q;
  end

endmodule

// File: tb/tb_pmem_burst_model.sv
// Directed bench for pmem_burst_model with the default parameter set.
module tb_pmem_burst_model;

  localparam int BW = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   ch_read, ch_write, ch_resp;
  logic [63:0]  ch_addr;
  logic [127:0] ch_wdata, ch_rdata;
  logic         busy;
  logic [0:0]   cur_ch;
  logic         error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_burst_model #(
    .NUM_CH(2), .DELAY_MEM(20), .DELAY_PAGE_HIT(6), .BURST_LEN(4),
    .CACHE_LINE_WIDTH(256), .PAGE_SIZE(2048), .DEPTH(1024)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .busy(busy), .cur_ch(cur_ch), .error(error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer with a well-behaved requester. lat counts edges from
  // the grant edge to the start of the first resp cycle.
  task automatic xfer(input int ch, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wline, output int lat, output int gnt,
                      output logic [255:0] rline, output bit stray);
    int n;
    int beats;
    lat = -1; gnt = -1; rline = '0; stray = 1'b0; n = 0; beats = 0;
    ch_addr[32*ch +: 32] = addr;
    ch_wdata[BW*ch +: BW] = wline[BW-1:0];
    if (wr) ch_write[ch] = 1'b1;
    else    ch_read[ch]  = 1'b1;
    while (beats < 4 && n < 200) begin
      tick();
      n++;
      if (n == 1 && busy) gnt = int'(cur_ch);
      if (wr && beats < 4) ch_wdata[BW*ch +: BW] = wline[BW*beats +: BW];
      if ((ch_resp & ~(2'b01 << ch)) != 2'b00) stray = 1'b1;
      if (ch_resp[ch]) begin
        if (beats == 0) lat = n - 1;
        rline[BW*beats +: BW] = ch_rdata[BW*ch +: BW];
        beats++;
      end
    end
    check("xfer_beats", beats, 4);
    tick();                     // COOL
    ch_read[ch]  = 1'b0;
    ch_write[ch] = 1'b0;
    tick();                     // back in IDLE
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c, rl;
    int           lat, gnt, n, beats, c;
    bit           stray;

    line_a = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
              64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
    line_b = {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
              64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000};
    line_c = {64'hCCCC_0000_0000_0003, 64'hCCCC_0000_0000_0002,
              64'hCCCC_0000_0000_0001, 64'hCCCC_0000_0000_0000};

    rst = 1'b1; ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
    #2 rst = 1'b0;
    #10;
    check("rst_resp",  ch_resp,  2'b00);
    check("rst_busy",  busy,     1'b0);
    check("rst_curch", cur_ch,   1'b0);
    check("rst_error", error,    1'b0);
    check("rst_rdata", ch_rdata, 128'h0);
    tick();
    rst = 1'b1;
    tick();

    // Write then read the same line: miss then page hit.
    xfer(0, 1'b1, 32'h0000_1000, line_a, lat, gnt, rl, stray);
    check("wr1000_lat", lat, 20);
    check("wr1000_gnt", gnt, 0);
    check("wr1000_stray", stray, 1'b0);
    xfer(0, 1'b0, 32'h0000_1000, '0, lat, gnt, rl, stray);
    check("rd1000_lat", lat, 6);
    check("rd1000_data", rl, line_a);

    // Offset bits are ignored; page changes drive the latency; page tracking
    // is shared between channels.
    xfer(0, 1'b0, 32'h0000_1010, '0, lat, gnt, rl, stray);
    check("rd1010_lat", lat, 6);
    check("rd1010_data", rl, line_a);
    xfer(0, 1'b0, 32'h0000_1800, '0, lat, gnt, rl, stray);
    check("rd1800_lat", lat, 20);
    xfer(1, 1'b0, 32'h0000_1840, '0, lat, gnt, rl, stray);
    check("rd1840_lat", lat, 6);
    check("rd1840_gnt", gnt, 1);
    check("rd1840_stray", stray, 1'b0);

    // Both channels requesting: grants alternate starting at ch0.
    ch_addr = {32'h0000_4020, 32'h0000_4000};
    ch_read = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!busy && n < 50) begin
        tick();
        n++;
      end
      c = int'(cur_ch);
      check("arb_grant", c, g % 2);
      beats = 0; stray = 1'b0; n = 0;
      while (beats < 4 && n < 60) begin
        tick();
        n++;
        if (ch_resp[c])     beats++;
        if (ch_resp[1 - c]) stray = 1'b1;
      end
      check("arb_beats", beats, 4);
      check("arb_stray", stray, 1'b0);
      tick();
      ch_read[c] = 1'b0;
      tick();
      ch_read[c] = 1'b1;
    end
    ch_read = 2'b00;
    tick();

    // Address change during WAIT on ch1.
    check("pre_addr_err", error, 1'b0);
    ch_addr[63:32] = 32'h0000_2000;
    ch_read[1] = 1'b1;
    tick();
    check("addr_busy", busy, 1'b1);
    check("addr_curch", cur_ch, 1'b1);
    tick();
    ch_addr[63:32] = 32'h0000_2020;
    tick();
    check("addr_err", error, 1'b1);
    check("addr_idle", busy, 1'b0);
    check("addr_resp", ch_resp, 2'b00);
    ch_read[1] = 1'b0;
    tick();
    check("addr_resp_after", ch_resp, 2'b00);
    xfer(0, 1'b0, 32'h0000_1000, '0, lat, gnt, rl, stray);
    check("after_err_lat", lat, 20);
    check("after_err_data", rl, line_a);

    // Reset in the middle of beat 2 of a write.
    xfer(0, 1'b1, 32'h0000_3000, line_b, lat, gnt, rl, stray);
    ch_addr[31:0]  = 32'h0000_3000;
    ch_wdata[63:0] = line_c[63:0];
    ch_write[0]    = 1'b1;
    beats = 0; n = 0;
    while (beats < 3 && n < 100) begin
      tick();
      n++;
      ch_wdata[63:0] = line_c[BW*beats +: BW];
      if (ch_resp[0]) beats++;
    end
    check("rstw_beats", beats, 3);
    rst = 1'b0;
    #1;
    check("rstw_resp",  ch_resp,  2'b00);
    check("rstw_busy",  busy,     1'b0);
    check("rstw_error", error,    1'b0);
    check("rstw_curch", cur_ch,   1'b0);
    check("rstw_rdata", ch_rdata, 128'h0);
    ch_write = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    xfer(0, 1'b0, 32'h0000_3000, '0, lat, gnt, rl, stray);
    check("rstw_rd_lat", lat, 20);
    check("rstw_rd_data", rl, {line_b[255:128], line_c[127:0]});

    // ch0 asserts read and write together: flagged and skipped, ch1 served.
    check("pre_dual_err", error, 1'b0);
    ch_addr[31:0] = 32'h0000_5000;
    ch_read[0]  = 1'b1;
    ch_write[0] = 1'b1;
    xfer(1, 1'b0, 32'h0000_1000, '0, lat, gnt, rl, stray);
    check("dual_gnt", gnt, 1);
    check("dual_lat", lat, 20);
    check("dual_data", rl, line_a);
    check("dual_stray", stray, 1'b0);
    check("dual_err", error, 1'b1);
    ch_read  = 2'b00;
    ch_write = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_burst_model.md
Name: pmem_burst_model

Overview:
- Parametrised, synthesizable physical-memory model: line storage, configurable page-hit/page-miss latency, burst transfers.
- Serves NUM_CH requester channels (e.g. I-cache and D-cache) through a round-robin arbiter.
- Checks the request protocol and reports violations on a sticky error flag.
- Sits below the cache/arbiter hierarchy in place of a single-port behavioural memory.

Parameters:
NUM_CH, 2, number of requester channels (1..8)
DELAY_MEM, 20, cycles from grant to first beat on a page miss (>=1)
DELAY_PAGE_HIT, 6, cycles from grant to first beat on a page hit (>=1)
BURST_LEN, 4, beats per line transfer (power of 2)
CACHE_LINE_WIDTH, 256, line width in bits; BURST_WIDTH = CACHE_LINE_WIDTH/BURST_LEN
PAGE_SIZE, 2048, page size in bytes (power of 2)
DEPTH, 1024, number of stored lines (power of 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ch_read  in  NUM_CH  per-channel read request
ch_write  in  NUM_CH  per-channel write request
ch_addr  in  NUM_CH*32  per-channel byte address, channel i at [32*i +: 32]
ch_wdata  in  NUM_CH*BURST_WIDTH  per-channel write beat
ch_rdata  out  NUM_CH*BURST_WIDTH  per-channel read beat
ch_resp  out  NUM_CH  per-channel beat-valid strobe
busy  out  1  transaction in progress (state != IDLE)
cur_ch  out  $clog2(NUM_CH) (min 1)  channel currently granted
error  out  1  sticky protocol-violation flag

Behaviour:
- Reset values:
  - ch_resp=0, ch_rdata=0, busy=0, cur_ch=0, error=0.
  - State IDLE, open-page register invalid, round-robin pointer at channel 0.
  - Storage is not cleared.
- States: IDLE -> WAIT -> BURST -> COOL -> IDLE.
- IDLE:
  - Eligible channel: read XOR write asserted.
  - Channel with both read and write asserted: set error; channel ignored this cycle.
  - Grant: first eligible channel at or after the RR pointer.
  - On the grant edge capture channel, op, and addr. RR pointer becomes granted+1 mod NUM_CH.
- Latency:
  - page = addr/PAGE_SIZE. Hit if open page is valid and equal to page; hit latency DELAY_PAGE_HIT, otherwise DELAY_MEM.
  - Open page is updated to the new page at the grant edge.
  - Page tracking is shared across all channels.
- WAIT: count down the latency. The first ch_resp cycle is the cycle beginning exactly DELAY edges after the grant edge.
- BURST: ch_resp[cur_ch] is high for BURST_LEN consecutive cycles; beat i occupies bits [BURST_WIDTH*i +: BURST_WIDTH].
  - Read: ch_rdata[cur_ch] holds beat i during resp cycle i. Non-granted channels' rdata hold their last value.
  - Write: on each rising edge ending a resp-high cycle, ch_wdata[cur_ch] is written into beat i. Requester advances its beat after each sampled resp.
- Line index: (addr >> log2(CACHE_LINE_WIDTH/8)) mod DEPTH. Low offset bits are ignored.
- COOL: one mandatory idle cycle after the last beat; requests are ignored. Requester must drop read/write by the end of this cycle.
- Protocol checks, every cycle in WAIT/BURST on the granted channel:
  - Violations: op line deasserted, opposite op asserted, or addr changed.
  - On violation: set error, drop resp next cycle, go to IDLE.
  - A write aborted mid-burst keeps the beats already written.
- Requests on non-granted channels during a transaction are held pending, not errors.
- rst asserted mid-operation: immediate return to reset values. Storage keeps beats already written.

Test Plan:
- Write line 0x1000 (beats A0..A3) on ch0, then read 0x1000 on ch0 -> first resp 20 cycles after write grant; read resp 6 cycles after read grant (page hit); rdata A0..A3.
- Read 0x1000, then read 0x1800 (different page) -> second first-beat latency 20; then 0x1840 -> latency 6.
- ch0 and ch1 both request reads in the same cycle, repeated 4 times -> grants alternate ch0,ch1,ch0,ch1; resp only on the granted channel.
- ch1 read with addr changed from 0x2000 to 0x2020 during WAIT -> error=1 next cycle; resp never asserted; next request still serviced.
- ch0 read and write asserted together in IDLE -> error=1; no grant to ch0; ch1 request granted in the same cycle.
- rst asserted during BURST beat 2 of a write to 0x3000 -> resp=0, busy=0 immediately; subsequent read of 0x3000 (latency 20) returns new beats 0..1 and old beats 2..3.
